// File: rtl/scpu_isa_pkg.sv
// Shared ISA definitions for the single-cycle CPU: instruction-word field
// positions, tuple kinds, opcode flags and ALU command codes. scpu_decoder
// unpacks with the same constants, so the two stay in lock-step.
package scpu_isa_pkg;

  // tuple kinds on the encoder input
  localparam logic [1:0] KIND_NOP = 2'b00;
  localparam logic [1:0] KIND_R   = 2'b01;
  localparam logic [1:0] KIND_I   = 2'b10;
  localparam logic [1:0] KIND_ILL = 2'b11;

  // word layout; rs2 and imm15 share the upper field
  localparam int IMM_LSB   = 17;
  localparam int IMM_W     = 15;
  localparam int RS2_LSB   = 17;
  localparam int RS1_LSB   = 12;
  localparam int RD_LSB    = 7;
  localparam int ALU_LSB   = 2;
  localparam int IFLAG_BIT = 1;
  localparam int RFLAG_BIT = 0;

  // aluCmd codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_SLL = 3'd6;
  localparam logic [2:0] ALU_SRL = 3'd7;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [15:0] imm;
  } insn_fields_t;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} enc_state_e;

endpackage

// File: rtl/scpu_encoder_if.sv
// Encoder data paths: the field-tuple input channel and the instruction-memory
// write channel, both valid/ready. slave = encoder view, master = producer and
// memory side.
interface scpu_encoder_if #(parameter int AW = 8);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_kind;
  logic [2:0]    in_alu;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [15:0]   in_imm;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;

  modport slave (
    input  in_valid, in_kind, in_alu, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
    output in_ready, mem_valid, mem_addr, mem_data
  );

  modport master (
    output in_valid, in_kind, in_alu, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
    input  in_ready, mem_valid, mem_addr, mem_data
  );
endinterface

// File: rtl/scpu_insn_pack.sv
// Combinational packer: decoded fields -> 32-bit instruction word plus
// error flags. Illegal kinds become NOP; oversize immediates are truncated.
module scpu_insn_pack
  import scpu_isa_pkg::*;
(
  input  insn_fields_t fields,
  output logic [31:0]  word,
  output logic         immErr,
  output logic         kindErr
);

  // place only the fields the kind uses; everything else stays zero
  always_comb begin
    word    = '0;
    immErr  = 1'b0;
    kindErr = 1'b0;
    unique case (fields.kind)
      KIND_R: begin
        word[RS2_LSB +: 5]  = fields.rs2;
        word[RS1_LSB +: 5]  = fields.rs1;
        word[RD_LSB +: 5]   = fields.rd;
        word[ALU_LSB +: 3]  = fields.alu;
        word[RFLAG_BIT]     = 1'b1;
      end
      KIND_I: begin
        word[IMM_LSB +: IMM_W] = fields.imm[IMM_W-1:0];
        word[RS1_LSB +: 5]     = fields.rs1;
        word[RD_LSB +: 5]      = fields.rd;
        word[ALU_LSB +: 3]     = fields.alu;
        word[IFLAG_BIT]        = 1'b1;
        immErr                 = fields.imm[15];
      end
      KIND_ILL: kindErr = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/scpu_encoder.sv
// Streaming program loader: accepts field tuples, packs them and writes them
// to instruction memory at auto-incrementing (wrapping) addresses, one job of
// start_count words per start pulse.
module scpu_encoder
  import scpu_isa_pkg::*;
#(
  parameter int AW    = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [CNT_W-1:0] start_count,
  scpu_encoder_if.slave    bus,
  output logic             busy,
  output logic             done,
  output logic             err_imm,
  output logic             err_kind
);

  enc_state_e       state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] accepted;
  logic [CNT_W-1:0] written;
  logic [AW-1:0]    curAddr;
  logic [AW-1:0]    memAddr;
  logic [31:0]      memData;
  logic             memValid;

  insn_fields_t     fields;
  logic [31:0]      word;
  logic             immErr;
  logic             kindErr;
  logic             inReady;
  logic             accept;
  logic             memFire;

  assign fields = '{kind: bus.in_kind, alu: bus.in_alu, rd: bus.in_rd,
                    rs1: bus.in_rs1, rs2: bus.in_rs2, imm: bus.in_imm};

  scpu_insn_pack u_pack (
    .fields  (fields),
    .word    (word),
    .immErr  (immErr),
    .kindErr (kindErr)
  );

  // a new tuple can enter only if the single output slot is free or draining now
  assign inReady = (state == ST_LOAD) && (accepted < count) && (!memValid || bus.mem_ready);
  assign accept  = bus.in_valid && inReady;
  assign memFire = memValid && bus.mem_ready;

  assign bus.in_ready  = inReady;
  assign bus.mem_valid = memValid;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_data  = memData;

  // job FSM, counters and the registered write slot
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      accepted <= '0;
      written  <= '0;
      curAddr  <= '0;
      memAddr  <= '0;
      memData  <= '0;
      memValid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_imm  <= 1'b0;
      err_kind <= 1'b0;
    end else begin
      done <= 1'b0;
      if (memFire) begin
        memValid <= 1'b0;
        written  <= written + CNT_W'(1);
      end
      // a same-cycle accept refills the slot, overriding the clear above
      if (accept) begin
        memValid <= 1'b1;
        memAddr  <= curAddr;
        memData  <= word;
        curAddr  <= curAddr + AW'(1);
        accepted <= accepted + CNT_W'(1);
        if (immErr)  err_imm  <= 1'b1;
        if (kindErr) err_kind <= 1'b1;
      end
      unique case (state)
        ST_IDLE: if (start) begin
          curAddr  <= start_addr;
          count    <= start_count;
          accepted <= '0;
          written  <= '0;
          err_imm  <= 1'b0;
          err_kind <= 1'b0;
          if (start_count == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: if (accept && (accepted + CNT_W'(1) == count)) state <= ST_DRAIN;
        ST_DRAIN: if (memFire && (written + CNT_W'(1) == count)) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
